// File: rtl/costas_loop_filter_if.sv
// rtl/costas_loop_filter_if.sv - baseband sample stream in, NCO frequency correction and lock status out
interface costas_loop_filter_if #(
    parameter int DW = 16,
    parameter int EW = 20
);
    logic                 din_valid;
    logic signed [DW-1:0] i_in;
    logic signed [DW-1:0] q_in;
    logic signed [31:0]   freq_mod_o;
    logic                 fmod_valid;
    logic signed [EW-1:0] err_o;
    logic                 locked;

    modport master (
        output din_valid, i_in, q_in,
        input  freq_mod_o, fmod_valid, err_o, locked
    );

    modport slave (
        input  din_valid, i_in, q_in,
        output freq_mod_o, fmod_valid, err_o, locked
    );
endinterface

// File: rtl/costas_loop_filter.sv
// rtl/costas_loop_filter.sv - Costas phase detector, integrate-and-dump and clamped PI filter driving the NCO
// Three stages: dump -> integrator -> output/lock.
module costas_loop_filter #(
    parameter int          DW       = 16,
    parameter int          N_ACC    = 16,
    parameter int          KP_SHIFT = 10,
    parameter int          KI_SHIFT = 4,
    parameter logic [31:0] FMOD_MAX = 32'd16777216,
    parameter int          LOCK_THR = 256,
    parameter int          LOCK_CNT = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic                    loop_en,
    costas_loop_filter_if.slave     bus
);
    localparam int CW = $clog2(N_ACC);
    localparam int AW = DW + CW;
    localparam int LW = $clog2(LOCK_CNT + 1);

    localparam logic [CW-1:0]        CNT_LAST = CW'(N_ACC - 1);
    localparam logic [LW-1:0]        LOCK_TOP = LW'(LOCK_CNT);
    localparam logic signed [33:0]   FMAX     = $signed({2'b00, FMOD_MAX});
    localparam logic signed [33:0]   FMIN     = -FMAX;
    localparam logic signed [33:0]   THR      = 34'(LOCK_THR);
    localparam logic signed [DW-1:0] PD_MIN   = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] PD_MAX   = ~PD_MIN;

    logic signed [AW-1:0] r_acc;
    logic [CW-1:0]        r_cnt;
    logic signed [AW-1:0] r_err;
    logic                 r_dump;
    logic                 r_stage2;
    logic signed [31:0]   r_integ;
    logic signed [31:0]   r_freq;
    logic                 r_fmod_valid;
    logic signed [AW-1:0] r_err_o;
    logic [LW-1:0]        r_lock_cnt;
    logic                 r_locked;

    logic signed [DW-1:0] w_q_neg;
    logic signed [DW-1:0] w_pd;
    logic signed [AW-1:0] w_acc_sum;
    logic signed [33:0]   w_e34;
    logic signed [33:0]   w_integ34;
    logic signed [33:0]   w_integ_sum;
    logic signed [33:0]   w_fmod_sum;
    logic signed [33:0]   w_err_abs;
    logic                 w_good;
    logic [LW-1:0]        w_lock_next;

    function automatic logic signed [31:0] clamp(input logic signed [33:0] x);
        if (x > FMAX)
            return FMAX[31:0];
        else if (x < FMIN)
            return FMIN[31:0];
        else
            return x[31:0];
    endfunction

    // Negating the most negative Q would wrap, so it saturates instead.
    assign w_q_neg     = (bus.q_in == PD_MIN) ? PD_MAX : -bus.q_in;
    assign w_pd        = bus.i_in[DW-1] ? w_q_neg : bus.q_in;
    assign w_acc_sum   = r_acc + {{CW{w_pd[DW-1]}}, w_pd};

    assign w_e34       = {{(34-AW){r_err[AW-1]}}, r_err};
    assign w_integ34   = {{2{r_integ[31]}}, r_integ};
    assign w_integ_sum = w_integ34 + (w_e34 <<< KI_SHIFT);
    // Stage 2 sees the integrator value already updated by stage 1.
    assign w_fmod_sum  = (w_e34 <<< KP_SHIFT) + w_integ34;

    assign w_err_abs   = r_err[AW-1] ? -w_e34 : w_e34;
    assign w_good      = (w_err_abs < THR);
    assign w_lock_next = !w_good ? '0 :
                         (r_lock_cnt == LOCK_TOP) ? r_lock_cnt : r_lock_cnt + LW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_err        <= '0;
            r_dump       <= 1'b0;
            r_stage2     <= 1'b0;
            r_integ      <= '0;
            r_freq       <= '0;
            r_fmod_valid <= 1'b0;
            r_err_o      <= '0;
            r_lock_cnt   <= '0;
            r_locked     <= 1'b0;
        end else if (clken) begin
            if (!loop_en) begin
                r_acc        <= '0;
                r_cnt        <= '0;
                r_err        <= '0;
                r_dump       <= 1'b0;
                r_stage2     <= 1'b0;
                r_integ      <= '0;
                r_freq       <= '0;
                r_fmod_valid <= 1'b0;
                r_err_o      <= '0;
                r_lock_cnt   <= '0;
                r_locked     <= 1'b0;
            end else begin
                r_dump       <= 1'b0;
                r_stage2     <= r_dump;
                r_fmod_valid <= r_stage2;

                if (bus.din_valid) begin
                    if (r_cnt == CNT_LAST) begin
                        r_err  <= w_acc_sum;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        r_dump <= 1'b1;
                    end else begin
                        r_acc  <= w_acc_sum;
                        r_cnt  <= r_cnt + CW'(1);
                    end
                end

                if (r_dump)
                    r_integ <= clamp(w_integ_sum);

                if (r_stage2) begin
                    r_freq     <= clamp(w_fmod_sum);
                    r_err_o    <= r_err;
                    r_lock_cnt <= w_lock_next;
                    r_locked   <= (w_lock_next == LOCK_TOP);
                end
            end
        end
    end

    // A held pulse is only presented on enabled cycles so it is neither lost nor stretched.
    assign bus.fmod_valid = r_fmod_valid & clken;
    assign bus.freq_mod_o = r_freq;
    assign bus.err_o      = r_err_o;
    assign bus.locked     = r_locked;
endmodule
